// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: mem_op encodings, MMIO addresses and STATUS bit positions
package mem_responder_pkg;
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
  localparam logic [15:0] ADDR_STATUS = 16'hFF01;
  localparam logic [15:0] ADDR_RXDATA = 16'hFF02;
  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_UNF   = 3;
endpackage

// File: rtl/mem_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with guarded push/pop; head reads 0 while empty
module sync_fifo #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == DEPTH;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: MEM-stage word RAM plus TX/RX FIFO MMIO window.
// RX FIFO is built only when MEM_RESPONDER_RX_EN is defined.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  input  logic [1:0]  mem_op,
  output logic [15:0] read_data,
  output logic [15:0] io_out_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  input  logic [15:0] io_in_data,
  input  logic        io_in_valid,
  output logic        io_in_ready
);
  logic [15:0] ram [2**RAM_AW];
  logic is_ram, rd, wr, tx_push, tx_full, tx_empty, rx_pop, rx_empty, clr, tx_ovf, rx_unf;
  logic [15:0] rx_head, status;
  logic [FIFO_AW:0] tx_count_unused;
  assign is_ram  = 32'(address) < (32'd1 << RAM_AW);
  assign rd      = mem_op == MEM_READ;
  assign wr      = mem_op == MEM_WRITE;
  assign tx_push = wr && address == ADDR_TXDATA;
  assign rx_pop  = rd && address == ADDR_RXDATA;
  assign clr     = wr && address == ADDR_STATUS;
  assign io_out_valid = !tx_empty;
  sync_fifo #(.W(16), .AW(FIFO_AW)) u_tx (
    .clk, .reset, .push(tx_push), .pop(io_out_valid && io_out_ready), .din(write_data),
    .dout(io_out_data), .full(tx_full), .empty(tx_empty), .count(tx_count_unused)
  );
`ifdef MEM_RESPONDER_RX_EN
  logic rx_full;
  logic [FIFO_AW:0] rx_count_unused;
  assign io_in_ready = !rx_full;
  sync_fifo #(.W(16), .AW(FIFO_AW)) u_rx (
    .clk, .reset, .push(io_in_valid && io_in_ready), .pop(rx_pop), .din(io_in_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count_unused)
  );
`else
  logic unused_rx;
  assign unused_rx   = ^{io_in_data, io_in_valid};
  assign io_in_ready = 1'b0;
  assign rx_empty    = 1'b1;
  assign rx_head     = '0;
`endif
  always_ff @(posedge clk)
    if (wr && is_ram) ram[address[RAM_AW-1:0]] <= write_data;
  // a set in the same cycle as a STATUS write wins over the clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      tx_ovf <= (tx_push && tx_full) || (tx_ovf && !clr);
      rx_unf <= (rx_pop && rx_empty) || (rx_unf && !clr);
    end
  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_UNF]   = rx_unf;
  end
  assign read_data = !rd ? '0 :
                     is_ram ? ram[address[RAM_AW-1:0]] :
                     address == ADDR_STATUS ? status :
                     address == ADDR_RXDATA ? rx_head : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus random stimulus against a queue-based reference model
module tb_mem_responder;
`ifdef MEM_RESPONDER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] address = '0, write_data = '0, io_in_data = '0;
  logic [1:0] mem_op = '0;
  logic io_out_ready = 1'b0, io_in_valid = 1'b0;
  logic [15:0] read_data, io_out_data;
  logic io_out_valid, io_in_ready;
  int vectors = 0, miscompares = 0;
  logic [15:0] ram_m [int];
  logic [15:0] txq [$];
  logic [15:0] rxq [$];
  bit ovf_m = 0, unf_m = 0;
  logic [15:0] addr_tab [7] = '{16'h0005, 16'h0010, 16'h0100, 16'hFF00, 16'hFF01, 16'hFF02, 16'hFFFF};

  mem_responder dut (
    .clk(clk), .reset(reset), .address(address), .write_data(write_data), .mem_op(mem_op),
    .read_data(read_data), .io_out_data(io_out_data), .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] status_m();
    return {12'b0, unf_m, ovf_m, rxq.size() == 0, txq.size() == DEPTH};
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ovf_m = 0;
    unf_m = 0;
  endtask

  task automatic step(input logic [1:0] op, input logic [15:0] a, input logic [15:0] wd,
                      input logic ordy, input logic ivld, input logic [15:0] idat);
    logic [15:0] exp_rd;
    bit check_rd, tx_pop, tx_push, rx_pop, rx_push, ovf_s, unf_s, clr;
    mem_op = op; address = a; write_data = wd;
    io_out_ready = ordy; io_in_valid = ivld; io_in_data = idat;
    #4;
    exp_rd = '0;
    check_rd = 1;
    if (op == 2'b01) begin
      if (a < 16'd256) begin
        if (ram_m.exists(int'(a))) exp_rd = ram_m[int'(a)];
        else check_rd = 0;
      end else if (a == 16'hFF01) exp_rd = status_m();
      else if (a == 16'hFF02) exp_rd = rxq.size() != 0 ? rxq[0] : 16'h0;
    end
    if (check_rd) chk("read_data", read_data, exp_rd);
    chk("io_out_valid", {15'b0, io_out_valid}, {15'b0, txq.size() != 0});
    chk("io_out_data", io_out_data, txq.size() != 0 ? txq[0] : 16'h0);
    chk("io_in_ready", {15'b0, io_in_ready}, {15'b0, RX_EN && rxq.size() < DEPTH});
    tx_pop  = txq.size() != 0 && ordy;
    tx_push = op == 2'b10 && a == 16'hFF00;
    ovf_s   = tx_push && txq.size() == DEPTH;
    rx_pop  = op == 2'b01 && a == 16'hFF02;
    unf_s   = rx_pop && rxq.size() == 0;
    rx_push = RX_EN && ivld && rxq.size() < DEPTH;
    clr     = op == 2'b10 && a == 16'hFF01;
    if (op == 2'b10 && a < 16'd256) ram_m[int'(a)] = wd;
    if (tx_pop) void'(txq.pop_front());
    if (tx_push && !ovf_s) txq.push_back(wd);
    if (rx_pop && rxq.size() != 0) void'(rxq.pop_front());
    if (rx_push) rxq.push_back(idat);
    ovf_m = ovf_s || (ovf_m && !clr);
    unf_m = unf_s || (unf_m && !clr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    step(2'b01, 16'hFF01, 0, 0, 0, 0);
    chk("status_after_reset_const", read_data, 16'h0002);
    step(2'b10, 16'h0005, 16'h1234, 0, 0, 0);
    step(2'b01, 16'h0005, 0, 0, 0, 0);
    step(2'b01, 16'h0100, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(2'b10, 16'hFF00, 16'h000A + 16'(i), 0, 0, 0);
    step(2'b01, 16'hFF01, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(2'b00, 0, 0, 1, 0, 0);
    step(2'b10, 16'hFF01, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(2'b10, 16'hFF00, 16'h0020 + 16'(i), 0, 0, 0);
    step(2'b10, 16'hFF00, 16'h00FF, 1, 0, 0);
    step(2'b01, 16'hFF01, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 1, 0, 0);
    step(2'b10, 16'hFF01, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 1, 16'hBEEF);
    step(2'b00, 0, 0, 0, 1, 16'hCAFE);
    for (int i = 0; i < 3; i++) step(2'b01, 16'hFF02, 0, 0, 0, 0);
    step(2'b01, 16'hFF01, 0, 0, 0, 0);
    step(2'b10, 16'hFF01, 0, 0, 0, 0);
    step(2'b01, 16'hFF01, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 0, 1, 16'h0100 + 16'(i));
    step(2'b01, 16'hFF02, 0, 0, 1, 16'h0200);
    for (int i = 0; i < 4; i++) step(2'b01, 16'hFF02, 0, 0, 0, 0);
    step(2'b10, 16'hFF01, 0, 0, 0, 0);
    step(2'b10, 16'hFF00, 16'h0055, 0, 1, 16'h0301);
    step(2'b10, 16'hFF00, 16'h0056, 0, 1, 16'h0302);
    mem_op = 2'b01; address = 16'hFF01; io_out_ready = 1'b0; io_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("reset_io_out_valid", {15'b0, io_out_valid}, 16'h0000);
    chk("reset_io_out_data", io_out_data, 16'h0000);
    chk("reset_status", read_data, 16'h0002);
    chk("reset_io_in_ready", {15'b0, io_in_ready}, {15'b0, RX_EN});
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 6)], 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
